// File: rtl/nx_indirect_access_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one register-indirect
// command engine, with one command in flight, a completion timeout and stray-done accounting.
module nx_indirect_access_arbiter #(
  parameter int N_REQ          = 4,
  parameter int N_ADDR_BITS    = 5,
  parameter int N_DATA_BITS    = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_REQ-1:0]               req_valid,
  input  logic [4*N_REQ-1:0]             req_op,
  input  logic [N_ADDR_BITS*N_REQ-1:0]   req_addr,
  input  logic [N_DATA_BITS*N_REQ-1:0]   req_wdat,
  output logic [N_REQ-1:0]               req_ready,
  output logic [N_REQ-1:0]               rsp_valid,
  output logic [2:0]                     rsp_code,
  output logic [N_DATA_BITS-1:0]         rsp_rdat,
  output logic                           eng_cmnd_valid,
  output logic [3:0]                     eng_cmnd_op,
  output logic [N_ADDR_BITS-1:0]         eng_cmnd_addr,
  output logic [N_DATA_BITS-1:0]         eng_wdat,
  input  logic                           eng_busy,
  input  logic                           eng_done,
  input  logic [2:0]                     eng_stat_code,
  input  logic [N_DATA_BITS-1:0]         eng_rdat,
  output logic [7:0]                     timeout_cnt,
  output logic [7:0]                     stray_done_cnt
);

  localparam int IDW = $clog2(N_REQ);
  localparam int SW  = IDW + 1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [IDW-1:0]     rr_ptr, grant_id, gnt_idx, rr_nxt;
  logic [SW-1:0]      gnt_sum, gnt_inc;
  logic [2*N_REQ-1:0] vld_dbl;
  logic [N_REQ-1:0]   vld_rot;
  logic               any_vld;
  logic               timeout_hit;
  logic [7:0]         timer;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Rotate the request vector so that bit 0 is the requester at rr_ptr.
  assign vld_dbl = {req_valid, req_valid};
  assign vld_rot = vld_dbl[rr_ptr +: N_REQ];

  always_comb begin
    any_vld = 1'b0;
    gnt_sum = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (vld_rot[k]) begin
        any_vld = 1'b1;
        gnt_sum = {1'b0, rr_ptr} + SW'(k);
      end
    end
    gnt_idx = (gnt_sum >= SW'(N_REQ)) ? IDW'(gnt_sum - SW'(N_REQ)) : gnt_sum[IDW-1:0];
    gnt_inc = {1'b0, gnt_idx} + SW'(1);
    rr_nxt  = (gnt_inc == SW'(N_REQ)) ? '0 : gnt_inc[IDW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Strobes are suppressed during reset so an accept or issue cannot be lost.
  always_comb begin
    state_nxt      = state;
    req_ready      = '0;
    rsp_valid      = '0;
    eng_cmnd_valid = 1'b0;
    timeout_hit    = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: if (any_vld) begin
          req_ready[gnt_idx] = 1'b1;
          state_nxt          = ISSUE;
        end
        ISSUE: if (!eng_busy) begin
          eng_cmnd_valid = 1'b1;
          state_nxt      = WAIT;
        end
        WAIT: begin
          if (eng_done) begin
            state_nxt = RESP;
          end else if (timer == TMO_LAST) begin
            timeout_hit = 1'b1;
            state_nxt   = RESP;
          end
        end
        RESP: begin
          rsp_valid[grant_id] = 1'b1;
          state_nxt           = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr         <= '0;
      grant_id       <= '0;
      eng_cmnd_op    <= '0;
      eng_cmnd_addr  <= '0;
      eng_wdat       <= '0;
      timer          <= '0;
      rsp_code       <= '0;
      rsp_rdat       <= '0;
      timeout_cnt    <= '0;
      stray_done_cnt <= '0;
    end else begin
      if (|req_ready) begin
        eng_cmnd_op   <= req_op[gnt_idx*4 +: 4];
        eng_cmnd_addr <= req_addr[gnt_idx*N_ADDR_BITS +: N_ADDR_BITS];
        eng_wdat      <= req_wdat[gnt_idx*N_DATA_BITS +: N_DATA_BITS];
        grant_id      <= gnt_idx;
        rr_ptr        <= rr_nxt;
      end
      if (eng_cmnd_valid)
        timer <= '0;
      else if (state == WAIT && !eng_done && !timeout_hit)
        timer <= timer + 8'd1;
      // A done in the final WAIT cycle takes priority over the timeout.
      if (state == WAIT && eng_done) begin
        rsp_code <= eng_stat_code;
        rsp_rdat <= eng_rdat;
      end else if (timeout_hit) begin
        rsp_code    <= 3'b111;
        rsp_rdat    <= '0;
        timeout_cnt <= sat_inc(timeout_cnt);
      end
      if (eng_done && state != WAIT)
        stray_done_cnt <= sat_inc(stray_done_cnt);
    end
  end

endmodule

// File: tb/tb_nx_indirect_access_arbiter.sv
// Scoreboard bench for nx_indirect_access_arbiter: directed scenarios plus
// randomized transactions checked against a round-robin/latency reference model.
module tb_nx_indirect_access_arbiter;

  localparam int N   = 4;
  localparam int AW  = 5;
  localparam int DW  = 64;
  localparam int TMO = 255;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [4*N-1:0]  req_op;
  logic [AW*N-1:0] req_addr;
  logic [DW*N-1:0] req_wdat;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [2:0]      rsp_code;
  logic [DW-1:0]   rsp_rdat;
  logic            eng_cmnd_valid;
  logic [3:0]      eng_cmnd_op;
  logic [AW-1:0]   eng_cmnd_addr;
  logic [DW-1:0]   eng_wdat;
  logic            eng_busy;
  logic            eng_done;
  logic [2:0]      eng_stat_code;
  logic [DW-1:0]   eng_rdat;
  logic [7:0]      timeout_cnt;
  logic [7:0]      stray_done_cnt;

  nx_indirect_access_arbiter #(
    .N_REQ(N), .N_ADDR_BITS(AW), .N_DATA_BITS(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdat(req_wdat),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_code(rsp_code), .rsp_rdat(rsp_rdat),
    .eng_cmnd_valid(eng_cmnd_valid), .eng_cmnd_op(eng_cmnd_op),
    .eng_cmnd_addr(eng_cmnd_addr), .eng_wdat(eng_wdat),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_stat_code(eng_stat_code),
    .eng_rdat(eng_rdat), .timeout_cnt(timeout_cnt), .stray_done_cnt(stray_done_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [2:0]  code;
    logic [63:0] rdat;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  int m_rr    = 0;
  int m_to    = 0;
  int m_stray = 0;

  logic [3:0]  ops[N];
  logic [4:0]  addrs[N];
  logic [63:0] wdats[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (m[i]) return i;
    end
    return 0;
  endfunction

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      ops[i]   = 4'($urandom);
      addrs[i] = 5'($urandom);
      wdats[i] = {$urandom, $urandom};
    end
  endtask

  task automatic drive_fields();
    for (int i = 0; i < N; i++) begin
      req_op[i*4 +: 4]    = ops[i];
      req_addr[i*AW +: AW] = addrs[i];
      req_wdat[i*DW +: DW] = wdats[i];
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_code"}, 64'(rsp_code), 64'd0);
    chk({tag, "_rsp_rdat"}, rsp_rdat, 64'd0);
    chk({tag, "_cmnd_valid"}, 64'(eng_cmnd_valid), 64'd0);
    chk({tag, "_cmnd_op"}, 64'(eng_cmnd_op), 64'd0);
    chk({tag, "_cmnd_addr"}, 64'(eng_cmnd_addr), 64'd0);
    chk({tag, "_wdat"}, eng_wdat, 64'd0);
    chk({tag, "_timeout_cnt"}, 64'(timeout_cnt), 64'd0);
    chk({tag, "_stray_cnt"}, 64'(stray_done_cnt), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; req_valid = '0; eng_done = 1'b0; eng_busy = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_rr = 0; m_to = 0; m_stray = 0;
    sbq.delete();
  endtask

  // One full command: accept, (stalled) issue, engine completion after dly
  // cycles (dly > TMO means the engine never answers).
  task automatic do_txn(input logic [3:0] mask, input int busy, input int dly,
                        input logic [2:0] code, input logic [63:0] rdat);
    int   g, n, t0;
    exp_t e;
    g = rr_pick(mask, m_rr);
    @(posedge clk); #1;
    drive_fields();
    req_valid = mask;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant", 64'(req_ready), 64'(4'b1 << g));
    t0   = cyc;
    m_rr = (g + 1) % N;
    e.id   = g;
    e.code = (dly <= TMO) ? code : 3'b111;
    e.rdat = (dly <= TMO) ? rdat : 64'd0;
    e.cyc  = t0 + busy + 2 + ((dly < TMO) ? dly : TMO);
    if (dly > TMO && m_to < 255) m_to++;
    sbq.push_back(e);
    n = 0;
    do begin
      @(posedge clk); #1;
      if (n == 0) req_valid = mask & ~(4'b1 << g);
      eng_busy = (n < busy);
      @(negedge clk);
      n++;
    end while (!eng_cmnd_valid && n < 300);
    chk("issue_delay", 64'(n), 64'(busy + 1));
    chk("issue_op", 64'(eng_cmnd_op), 64'(ops[g]));
    chk("issue_addr", 64'(eng_cmnd_addr), 64'(addrs[g]));
    chk("issue_wdat", eng_wdat, wdats[g]);
    if (dly <= TMO) begin
      repeat (dly) begin
        @(posedge clk); #1;
      end
      eng_done = 1'b1; eng_stat_code = code; eng_rdat = rdat;
      @(posedge clk); #1;
      eng_done = 1'b0; eng_stat_code = 3'($urandom); eng_rdat = {$urandom, $urandom};
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid == '0 && n < 300);
    chk("rsp_seen", 64'(rsp_valid != '0), 64'd1);
    @(posedge clk); #1;
    req_valid = '0;
    chk("timeout_cnt", 64'(timeout_cnt), 64'(m_to));
    chk("stray_cnt", 64'(stray_done_cnt), 64'(m_stray));
    chk("addr_stable", 64'(eng_cmnd_addr), 64'(addrs[g]));
  endtask

  task automatic stray_done();
    @(posedge clk); #1;
    eng_done = 1'b1;
    @(posedge clk); #1;
    eng_done = 1'b0;
    if (m_stray < 255) m_stray++;
    @(negedge clk);
    chk("stray_cnt", 64'(stray_done_cnt), 64'(m_stray));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_valid", 64'(rsp_valid), 64'(4'b1 << e.id));
          chk("rsp_code", 64'(rsp_code), 64'(e.code));
          chk("rsp_rdat", rsp_rdat, e.rdat);
          chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stimulus
    reset = 1'b1; req_valid = '0; req_op = '0; req_addr = '0; req_wdat = '0;
    eng_busy = 1'b0; eng_done = 1'b0; eng_stat_code = '0; eng_rdat = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // Single request on requester 2
    rand_fields();
    ops[2] = 4'h1; addrs[2] = 5'd7;
    do_txn(4'b0100, 0, 3, 3'd0, 64'hDEAD_BEEF_0000_0001);

    // Round-robin with all requesters asserted from reset
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rand_fields();
      do_txn(4'b1111, 0, 1, 3'(i), {$urandom, $urandom});
    end

    // Engine busy for six cycles after the grant
    rand_fields();
    do_txn(4'b0010, 6, 2, 3'd2, {$urandom, $urandom});

    // Timeout, then a late done counted as stray
    rand_fields();
    do_txn(4'b1000, 0, TMO + 1, 3'd0, 64'd0);
    stray_done();

    // Done on the last WAIT cycle wins over the timeout
    rand_fields();
    do_txn(4'b0001, 0, TMO, 3'd5, 64'h0123_4567_89AB_CDEF);

    // Reset while requester 1 is waiting on the engine
    rand_fields();
    @(posedge clk); #1;
    drive_fields();
    req_valid = 4'b0010;
    @(negedge clk);
    chk("rst_case_grant", 64'(req_ready), 64'd2);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_rr = 0; m_to = 0; m_stray = 0;
    @(negedge clk);
    check_zero("midreset");
    stray_done();
    rand_fields();
    do_txn(4'b1001, 0, 2, 3'd3, {$urandom, $urandom});

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      rand_fields();
      do_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(1, 10),
             3'($urandom), {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) stray_done();
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
